contador_rco_16b: RTL and testbench

- 16-bit synchronous up/down/load counter that the counter stimulus bench drives.
- Consumes enb, modo and D; produces Q and per-nibble ripple-carry flags RCO.
- Built as four cascaded 4-bit stages; the flags let a checker or downstream counter chain on nibble and full-width wrap events.

---
 rtl/contador_rco_16b.sv | 72 +++++++
 tb/tb_contador_rco_16b.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/contador_rco_16b.sv
// 16-bit up/down/load counter built from cascaded 4-bit stages.
// Q and the per-nibble carry/borrow flags RCO are registered.
module contador_rco_16b #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [NIB-1:0]   RCO
);

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DN1   = 2'b01;
  localparam logic [1:0] MODO_DN3   = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_nxt_c;
  logic [NIB-1:0]   rco_nxt_c;

  // Nibble chain: stage 0 applies the step, later stages take the carry/borrow of the stage below.
  always_comb begin
    logic       chain;
    logic [1:0] step;
    logic [4:0] sum;
    q_nxt_c   = Q;
    rco_nxt_c = '0;
    chain     = 1'b0;
    step      = 2'd0;
    sum       = 5'd0;
    for (int i = 0; i < int'(NIB); i++) begin
      if (i == 0) begin
        step = (modo == MODO_DN3) ? 2'd3 : 2'd1;
      end else begin
        step = {1'b0, chain};
      end
      if (modo == MODO_UP) begin
        sum = {1'b0, Q[4*i +: 4]} + {3'b000, step};
      end else begin
        sum = {1'b0, Q[4*i +: 4]} - {3'b000, step};
      end
      q_nxt_c[4*i +: 4] = sum[3:0];
      chain             = sum[4];
      rco_nxt_c[i]      = chain;
    end
  end

  // Flags are single-cycle pulses: cleared on hold, load and reset.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      Q   <= '0;
      RCO <= '0;
    end else if (enb) begin
      if (modo == MODO_LOAD) begin
        Q   <= D;
        RCO <= '0;
      end else begin
        Q   <= q_nxt_c;
        RCO <= rco_nxt_c;
      end
    end else begin
      RCO <= '0;
    end
  end

  logic unused_dn1;
  assign unused_dn1 = (MODO_DN1 == 2'b01);

endmodule

// File: tb/tb_contador_rco_16b.sv
// Scoreboard bench for contador_rco_16b: the driver queues expected Q/RCO,
// a monitor pops and compares one entry per clock after the edge.
module tb_contador_rco_16b;

  logic        clk;
  logic        reset_L;
  logic        enb;
  logic [1:0]  modo;
  logic [15:0] D;
  logic [15:0] Q;
  logic [3:0]  RCO;

  typedef struct packed {
    logic [15:0] q;
    logic [3:0]  r;
    logic        lng;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt0  = 0;
  int   cnt3  = 0;
  logic long_ph = 1'b0;

  contador_rco_16b dut (
    .clk    (clk),
    .reset_L(reset_L),
    .enb    (enb),
    .modo   (modo),
    .D      (D),
    .Q      (Q),
    .RCO    (RCO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: output is presented every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (Q !== e.q || RCO !== e.r) begin
          n_bad++;
          $display("FAIL qrco #%0d: got Q=%h RCO=%b, want Q=%h RCO=%b",
                   n_cmp, Q, RCO, e.q, e.r);
        end
        if (e.lng) begin
          if (RCO[0] === 1'b1) cnt0++;
          if (RCO[3] === 1'b1) cnt3++;
        end
      end
    end
  end

  task automatic step(input logic rst, input logic en, input logic [1:0] m,
                      input logic [15:0] d, input logic [15:0] eq,
                      input logic [3:0] er);
    exp_t e;
    @(negedge clk);
    reset_L = rst;
    enb     = en;
    modo    = m;
    D       = d;
    e.q     = eq;
    e.r     = er;
    e.lng   = long_ph;
    sb.push_back(e);
  endtask

  initial begin
    logic [15:0] kk;
    logic [3:0]  er;
    reset_L = 1'b0;
    enb     = 1'b0;
    modo    = 2'b00;
    D       = 16'h0000;

    // Reset with a count request, then hold
    repeat (2) step(1'b0, 1'b1, 2'b00, 16'h5555, 16'h0000, 4'b0000);
    repeat (5) step(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 4'b0000);

    // Load then count up through full wrap
    step(1'b1, 1'b1, 2'b11, 16'hFFFD, 16'hFFFD, 4'b0000);
    step(1'b1, 1'b1, 2'b00, 16'h0000, 16'hFFFE, 4'b0000);
    step(1'b1, 1'b1, 2'b00, 16'h0000, 16'hFFFF, 4'b0000);
    step(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0000, 4'b1111);
    step(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0001, 4'b0000);

    // Down by 1 across nibbles, then full-width borrow; hold clears the flags
    step(1'b1, 1'b1, 2'b11, 16'h0100, 16'h0100, 4'b0000);
    step(1'b1, 1'b1, 2'b01, 16'h0000, 16'h00FF, 4'b0011);
    step(1'b1, 1'b1, 2'b11, 16'h0000, 16'h0000, 4'b0000);
    step(1'b1, 1'b1, 2'b01, 16'h0000, 16'hFFFF, 4'b1111);
    step(1'b1, 1'b0, 2'b01, 16'h0000, 16'hFFFF, 4'b0000);

    // Multiple flags from one increment
    step(1'b1, 1'b1, 2'b11, 16'h0FFF, 16'h0FFF, 4'b0000);
    step(1'b1, 1'b1, 2'b00, 16'h0000, 16'h1000, 4'b0111);

    // Down by 3 wrap
    step(1'b1, 1'b1, 2'b11, 16'h0005, 16'h0005, 4'b0000);
    step(1'b1, 1'b1, 2'b10, 16'h0000, 16'h0002, 4'b0000);
    step(1'b1, 1'b1, 2'b10, 16'h0000, 16'hFFFF, 4'b1111);
    step(1'b1, 1'b1, 2'b10, 16'h0000, 16'hFFFC, 4'b0000);
    step(1'b1, 1'b1, 2'b10, 16'h0000, 16'hFFF9, 4'b0000);

    // Reset overrides a load in the same cycle, then resume from zero
    step(1'b1, 1'b1, 2'b11, 16'h1234, 16'h1234, 4'b0000);
    step(1'b1, 1'b1, 2'b00, 16'h0000, 16'h1235, 4'b0000);
    step(1'b0, 1'b1, 2'b11, 16'hAAAA, 16'h0000, 4'b0000);
    step(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0001, 4'b0000);

    // Long run: reset, load 0, count up 70000 times
    step(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 4'b0000);
    step(1'b1, 1'b1, 2'b11, 16'h0000, 16'h0000, 4'b0000);
    long_ph = 1'b1;
    for (int k = 1; k <= 70000; k++) begin
      kk    = 16'(k % 65536);
      er[0] = (kk[3:0] == 4'h0);
      er[1] = (kk[7:0] == 8'h00);
      er[2] = (kk[11:0] == 12'h000);
      er[3] = (kk == 16'h0000);
      step(1'b1, 1'b1, 2'b00, 16'h0000, kk, er);
    end
    long_ph = 1'b0;

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    n_cmp++;
    if (cnt3 != 1) begin
      n_bad++;
      $display("FAIL rco3_pulses: got %0d, want 1", cnt3);
    end
    n_cmp++;
    if (cnt0 != 4375) begin
      n_bad++;
      $display("FAIL rco0_pulses: got %0d, want 4375", cnt0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
